wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//  Round-robin bus arbiter for the shared wishbone crossbar path. It owns the master grant
//  decision and drives the one-hot grant vector and index that steer the crossbar's master mux.
//  Honours bus lock, re-arbitrates at transaction boundaries (no starvation) and aborts hung
//  transfers with a watchdog that injects a wishbone error.
// PARAMETERS
//  N_MASTER   4    number of requesting masters (>=1)
//  TIMEOUT    255  watchdog limit in cycles, stb without ack/err/rty; 0 disables the watchdog
//  IDXW       (N_MASTER>1 ? $clog2(N_MASTER) : 1)  width of the grant index (derived, do not override)
// PORTS
//  clk_i          in   1         clock
//  rstn_i         in   1         reset, asynchronous, active-low
//  cyc_i          in   N_MASTER  per-master wb_cyc (bus request)
//  stb_i          in   N_MASTER  per-master wb_stb
//  lock_i         in   N_MASTER  per-master wb_lock
//  ack_i          in   1         muxed slave ack (to the current grantee)
//  err_i          in   1         muxed slave err
//  rty_i          in   1         muxed slave rty
//  gnt_o          out  N_MASTER  one-hot grant, or all-zero
//  gnt_idx_o      out  IDXW      index of the grantee; 0 when none
//  busy_o         out  1         any grant active
//  locked_o       out  1         grant is held under lock
//  wdt_err_o      out  1         one-cycle error pulse to the grantee, ORed into its wb_err
// BEHAVIOUR
//  - Reset (rstn_i low, async): state IDLE, gnt_o=0, gnt_idx_o=0, busy_o=0, locked_o=0,
//    wdt_err_o=0, watchdog count=0, abort mask=0, rr pointer=N_MASTER-1.
//    Master 0 therefore wins first. Reset mid-transfer drops the grant immediately;
//    no error is injected.
//  - All outputs are registered. Grant latency is 1 cycle from cyc_i to gnt_o.
//  - Pick: first eligible requester strictly after the rr pointer, with wrap-around.
//    Eligible = cyc_i & ~abort_mask. On each new grant the pointer becomes the grantee index.
//  - Boundary: a cycle where stb_i[g] & (ack_i|err_i|rty_i), with g the grantee.
//  - State IDLE: if any requester is eligible, grant the pick and go to GRANT,
//    or to LOCKED if lock_i of the pick is high.
//  - State GRANT:
//    - cyc_i[g]=0: release. If another master is eligible, grant it the next cycle
//      (no idle gap); otherwise go to IDLE.
//    - boundary with another master eligible: hand over to the rr pick the next cycle.
//    - otherwise hold. lock_i[g] rising goes to LOCKED.
//  - State LOCKED: hold g regardless of other requests. Leave on cyc_i[g]=0, handled as the
//    GRANT release. If lock_i[g] falls, go to GRANT with no handover that cycle.
//  - Watchdog (TIMEOUT>0):
//    - count increments in GRANT/LOCKED while stb_i[g] & ~(ack_i|err_i|rty_i).
//    - count clears on a boundary, when stb_i[g]=0, or on a grant change.
//    - When count reaches TIMEOUT: wdt_err_o=1 for exactly one cycle, the grant is revoked
//      in the cycle after the pulse, and abort_mask[g] is set.
//    - abort_mask[g] clears when cyc_i[g] drops.
//    - A slave response arriving in the same cycle count reaches TIMEOUT wins: no pulse,
//      count clears.
//    - The count saturates and never wraps; its width is $clog2(TIMEOUT+1).
//  - N_MASTER=1: the pointer logic degenerates, and lock and watchdog still apply.
//  - Invariant: $onehot0(gnt_o); gnt_idx_o matches gnt_o; busy_o == |gnt_o.
// STRUCTURE
//  - Package wb_arb_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_LOCKED} arb_state_e;
//    plus function onehot2idx.
//  - Sub-module wb_rr_pick: purely combinational.
//    Inputs: req[N_MASTER] and ptr[IDXW]. Outputs: one-hot winner and valid.
//    Implemented as a double-width masked priority encoder.
//  - Top level: state register, pointer register, watchdog counter, abort mask, output registers.
// TESTING
//  1. Reset, then cyc_i=4'b0001 -> gnt_o=0001 one cycle later; gnt_idx_o=0; busy_o=1.
//  2. cyc_i=4'b1111 held, every master acking each stb -> grants rotate 0,1,2,3,0,
//     one per boundary; no master waits more than 3 transfers.
//  3. M1 granted with lock_i[1]=1, M0 and M2 requesting, 5 acked transfers -> gnt_o stays 0010.
//     Drop cyc_i[1] -> gnt_o=0100 next cycle (M2 follows pointer 1).
//  4. TIMEOUT=8, M0 stb high with no ack -> wdt_err_o pulses on the 9th stb cycle.
//     Then gnt_o=0 (or the next eligible master), and M0 is ignored until its cyc drops.
//  5. TIMEOUT=8, ack_i arrives in the cycle the count hits 8 -> no wdt_err_o; count clears.
//  6. Assert rstn_i low mid-transfer with M2 granted and locked -> all outputs 0 immediately.
//     After release with cyc_i=4'b0100, gnt_o=0100 one cycle later.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// ----------------------------------------------------------------------------
// wb_arb_pkg
//   Shared types and helpers for the wishbone round-robin arbiter.
//   - arb_state_e : arbiter FSM states (idle / granted / granted under lock)
//   - MAX_MASTER  : widest grant vector onehot2idx() can encode
//   - onehot2idx  : binary index of a one-hot vector (0 for an all-zero vector)
// ----------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_e;

    // onehot2idx() takes a fixed-width argument; grant vectors are
    // zero-extended to this width before the call.
    localparam int unsigned MAX_MASTER = 32;

    // ORing the indices of all set bits yields the index of a one-hot
    // vector and 0 for an empty one, without a priority chain.
    function automatic int unsigned onehot2idx(input logic [MAX_MASTER-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_MASTER; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// ----------------------------------------------------------------------------
// wb_rr_pick
//   Combinational round-robin pick: returns the first requester strictly after
//   the pointer, wrapping around.
//   Ports:
//     req    in   N_MASTER  request vector
//     ptr    in   IDXW      index of the last winner
//     winner out  N_MASTER  one-hot winner (all-zero when no request)
//     valid  out  1         at least one request present
// ----------------------------------------------------------------------------
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N_MASTER = 4,
    parameter int IDXW     = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
    input  logic [N_MASTER-1:0] req,
    input  logic [IDXW-1:0]     ptr,
    output logic [N_MASTER-1:0] winner,
    output logic                valid
);

    // The request vector is laid out twice side by side. Only the window
    // (ptr, ptr+N_MASTER] is allowed through, so a plain lowest-bit-first
    // priority encoder over the doubled vector gives the wrap-around order.
    logic [2*N_MASTER-1:0] dbl_req;
    logic [2*N_MASTER-1:0] dbl_win;
    logic                  found;

    genvar gi;
    generate
        for (gi = 0; gi < 2*N_MASTER; gi++) begin : g_dbl
            assign dbl_req[gi] = req[gi % N_MASTER]
                               && (gi > int'(ptr))
                               && (gi <= int'(ptr) + N_MASTER);
        end
    endgenerate

    always_comb begin
        dbl_win = '0;
        found   = 1'b0;
        for (int j = 0; j < 2*N_MASTER; j++) begin
            if (dbl_req[j] && !found) begin
                dbl_win[j] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Fold the two halves back onto the master indices.
    generate
        for (gi = 0; gi < N_MASTER; gi++) begin : g_fold
            assign winner[gi] = dbl_win[gi] | dbl_win[gi + N_MASTER];
        end
    endgenerate

    assign valid = |dbl_req;

endmodule

// File: rtl/wb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// wb_rr_arbiter
//   Round-robin grant decision for the shared wishbone crossbar path, with bus
//   lock, re-arbitration at transfer boundaries and a hung-transfer watchdog.
//   Ports:
//     clk_i      in   1         clock
//     rstn_i     in   1         asynchronous active-low reset
//     cyc_i      in   N_MASTER  per-master wb_cyc (bus request)
//     stb_i      in   N_MASTER  per-master wb_stb
//     lock_i     in   N_MASTER  per-master wb_lock
//     ack_i      in   1         muxed slave ack
//     err_i      in   1         muxed slave err
//     rty_i      in   1         muxed slave rty
//     gnt_o      out  N_MASTER  one-hot grant or all-zero
//     gnt_idx_o  out  IDXW      grantee index, 0 when idle
//     busy_o     out  1         a grant is active
//     locked_o   out  1         grant is held under lock
//     wdt_err_o  out  1         one-cycle watchdog error pulse to the grantee
// ----------------------------------------------------------------------------
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTER = 4,
    parameter int TIMEOUT  = 255,
    parameter int IDXW     = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [N_MASTER-1:0] cyc_i,
    input  logic [N_MASTER-1:0] stb_i,
    input  logic [N_MASTER-1:0] lock_i,
    input  logic                ack_i,
    input  logic                err_i,
    input  logic                rty_i,
    output logic [N_MASTER-1:0] gnt_o,
    output logic [IDXW-1:0]     gnt_idx_o,
    output logic                busy_o,
    output logic                locked_o,
    output logic                wdt_err_o
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e            state_reg, state_next;
    logic [N_MASTER-1:0]   gnt_reg, gnt_next;
    logic [IDXW-1:0]       ptr_reg, ptr_next;
    logic [IDXW-1:0]       idx_reg, idx_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [N_MASTER-1:0]   abort_reg, abort_next;
    logic                  wdt_reg, wdt_next;
    logic                  busy_reg, locked_reg;

    logic [N_MASTER-1:0]   elig;
    logic [N_MASTER-1:0]   pick_gnt;
    logic                  pick_valid;
    logic                  pick_lock;
    logic                  resp;
    logic                  cur_cyc, cur_stb, cur_lock;
    logic                  boundary;
    logic                  grant_change;
    logic                  drop, take;

    assign resp     = ack_i | err_i | rty_i;
    assign cur_cyc  = |(cyc_i  & gnt_reg);
    assign cur_stb  = |(stb_i  & gnt_reg);
    assign cur_lock = |(lock_i & gnt_reg);
    assign boundary = cur_stb & resp;

    // The current grantee is never a candidate: the picker only ever answers
    // "who else is waiting", which covers idle, release, handover and revoke.
    assign elig = cyc_i & ~abort_reg & ~gnt_reg;

    wb_rr_pick #(
        .N_MASTER (N_MASTER),
        .IDXW     (IDXW)
    ) u_pick (
        .req    (elig),
        .ptr    (ptr_reg),
        .winner (pick_gnt),
        .valid  (pick_valid)
    );

    assign pick_lock = |(lock_i & pick_gnt);

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        ptr_next   = ptr_reg;
        drop       = 1'b0;
        take       = 1'b0;

        unique case (state_reg)
            ARB_IDLE: begin
                take = pick_valid;
            end
            ARB_GRANT: begin
                // A pending watchdog pulse revokes the grant like a release.
                if (wdt_reg || !cur_cyc) begin
                    drop = 1'b1;
                end else if (cur_lock) begin
                    // Lock takes priority over a handover at the same boundary.
                    state_next = ARB_LOCKED;
                end else if (boundary && pick_valid) begin
                    take = 1'b1;
                end
            end
            ARB_LOCKED: begin
                if (wdt_reg || !cur_cyc) begin
                    drop = 1'b1;
                end else if (!cur_lock) begin
                    state_next = ARB_GRANT;
                end
            end
            default: begin
                drop = 1'b1;
            end
        endcase

        // Release hands straight over to a waiting master (no idle gap).
        if (drop) begin
            take = pick_valid;
            if (!pick_valid) begin
                state_next = ARB_IDLE;
                gnt_next   = '0;
            end
        end

        if (take) begin
            gnt_next   = pick_gnt;
            ptr_next   = IDXW'(onehot2idx(MAX_MASTER'(pick_gnt)));
            state_next = pick_lock ? ARB_LOCKED : ARB_GRANT;
        end
    end

    assign grant_change = (gnt_next != gnt_reg);
    assign idx_next     = IDXW'(onehot2idx(MAX_MASTER'(gnt_next)));

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT > 0) begin : g_wdt
            localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
            localparam logic [CW-1:0] CNT_PRE = CW'(TIMEOUT - 1);

            // The pulse is registered on the edge where the count reaches
            // TIMEOUT, so a response in that same cycle clears the count
            // instead and no pulse is raised.
            always_comb begin
                cnt_next = '0;
                wdt_next = 1'b0;
                if (!grant_change && (state_reg != ARB_IDLE) && cur_stb && !resp) begin
                    cnt_next = (cnt_reg != CNT_MAX) ? cnt_reg + 1'b1 : cnt_reg;
                    wdt_next = (cnt_reg == CNT_PRE);
                end
            end
        end else begin : g_no_wdt
            assign cnt_next = '0;
            assign wdt_next = 1'b0;
        end
    endgenerate

    // A master aborted by the watchdog stays excluded until it drops cyc.
    assign abort_next = (abort_reg | (wdt_reg ? gnt_reg : '0)) & cyc_i;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg  <= ARB_IDLE;
            gnt_reg    <= '0;
            ptr_reg    <= IDXW'(N_MASTER - 1);
            idx_reg    <= '0;
            cnt_reg    <= '0;
            abort_reg  <= '0;
            wdt_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            locked_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            ptr_reg    <= ptr_next;
            idx_reg    <= idx_next;
            cnt_reg    <= cnt_next;
            abort_reg  <= abort_next;
            wdt_reg    <= wdt_next;
            busy_reg   <= |gnt_next;
            locked_reg <= (state_next == ARB_LOCKED);
        end
    end

    assign gnt_o     = gnt_reg;
    assign gnt_idx_o = idx_reg;
    assign busy_o    = busy_reg;
    assign locked_o  = locked_reg;
    assign wdt_err_o = wdt_reg;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_rr_arbiter
//   Directed scenarios followed by a randomized run, every cycle compared with
//   an index-based behavioural model of the arbitration rules.
// ----------------------------------------------------------------------------
module tb_wb_rr_arbiter;

    localparam int NM  = 4;
    localparam int TMO = 8;
    localparam int IW  = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic [NM-1:0] cyc, stb, lock;
    logic          ack, err, rty;
    logic [NM-1:0] gnt;
    logic [IW-1:0] gnt_idx;
    logic          busy, locked, wdt_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state: grantee index (-1 = none), lock flag,
    // last-winner pointer, hang counter, pending pulse, aborted masters.
    int          m_g;
    bit          m_lk;
    int          m_ptr;
    int          m_cnt;
    bit          m_pulse;
    bit [NM-1:0] m_abort;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .N_MASTER (NM),
        .TIMEOUT  (TMO)
    ) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .cyc_i     (cyc),
        .stb_i     (stb),
        .lock_i    (lock),
        .ack_i     (ack),
        .err_i     (err),
        .rty_i     (rty),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .busy_o    (busy),
        .locked_o  (locked),
        .wdt_err_o (wdt_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input bit [NM-1:0] el, input int ptr);
        for (int k = 1; k <= NM; k++) begin
            if (el[(ptr + k) % NM]) return (ptr + k) % NM;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_g     = -1;
        m_lk    = 1'b0;
        m_ptr   = NM - 1;
        m_cnt   = 0;
        m_pulse = 1'b0;
        m_abort = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_next();
        bit          resp, gcyc, gstb, glock, do_pick, new_lk, pulse_n;
        bit [NM-1:0] el;
        int          other, new_g, cnt_n;
        resp  = ack | err | rty;
        gcyc  = (m_g >= 0) ? cyc[m_g]  : 1'b0;
        gstb  = (m_g >= 0) ? stb[m_g]  : 1'b0;
        glock = (m_g >= 0) ? lock[m_g] : 1'b0;
        for (int i = 0; i < NM; i++) el[i] = cyc[i] && !m_abort[i] && (i != m_g);
        other   = rr_pick(el, m_ptr);
        new_g   = m_g;
        new_lk  = m_lk;
        do_pick = 1'b0;
        if (m_g < 0)                              do_pick = 1'b1;
        else if (m_pulse || !gcyc)                do_pick = 1'b1;
        else if (m_lk)                            new_lk  = glock;
        else if (glock)                           new_lk  = 1'b1;
        else if (gstb && resp && other >= 0)      do_pick = 1'b1;
        if (do_pick) begin
            new_g  = other;
            new_lk = (other >= 0) ? lock[other] : 1'b0;
            if (other >= 0) m_ptr = other;
        end
        if (new_g == m_g && m_g >= 0 && gstb && !resp)
            cnt_n = (m_cnt < TMO) ? m_cnt + 1 : TMO;
        else
            cnt_n = 0;
        pulse_n = (cnt_n == TMO) && (m_cnt < TMO);
        if (m_pulse && m_g >= 0) m_abort[m_g] = 1'b1;
        m_abort = m_abort & cyc;
        m_g     = new_g;
        m_lk    = new_lk;
        m_cnt   = cnt_n;
        m_pulse = pulse_n;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_gnt"},    32'(gnt),     (m_g >= 0) ? (32'd1 << m_g) : 32'd0);
        chk({tag, "_idx"},    32'(gnt_idx), (m_g >= 0) ? 32'(m_g) : 32'd0);
        chk({tag, "_busy"},   32'(busy),    32'(m_g >= 0));
        chk({tag, "_locked"}, 32'(locked),  32'(m_lk));
        chk({tag, "_wdt"},    32'(wdt_err), 32'(m_pulse));
    endtask

    // One clock: model follows the applied inputs, outputs sampled 1 after the edge.
    task automatic step(input string tag);
        model_next();
        @(posedge clk);
        #1;
        check_model(tag);
        $display("step %-10s cyc=%b stb=%b lock=%b a/e/r=%b%b%b -> gnt=%b idx=%0d busy=%b lk=%b wdt=%b",
                 tag, cyc, stb, lock, ack, err, rty, gnt, gnt_idx, busy, locked, wdt_err);
    endtask

    task automatic set_in(input logic [NM-1:0] c, input logic [NM-1:0] s,
                          input logic [NM-1:0] l, input logic a);
        cyc  = c;
        stb  = s;
        lock = l;
        ack  = a;
        err  = 1'b0;
        rty  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int          exp_seq[5];
        bit [NM-1:0] lkst;
        int          r;
        bit          quiet;

        exp_seq = '{1, 2, 3, 0, 1};
        lkst    = '0;

        // ---- reset state ----
        rstn = 1'b0;
        set_in('0, '0, '0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",    32'(gnt),     32'd0);
        chk("rst_idx",    32'(gnt_idx), 32'd0);
        chk("rst_busy",   32'(busy),    32'd0);
        chk("rst_locked", 32'(locked),  32'd0);
        chk("rst_wdt",    32'(wdt_err), 32'd0);
        rstn = 1'b1;

        // ---- 1: first grant goes to master 0 after one cycle ----
        set_in(4'b0001, '0, '0, 1'b0);
        step("t1");
        chk("t1_gnt",  32'(gnt),     32'h1);
        chk("t1_idx",  32'(gnt_idx), 32'd0);
        chk("t1_busy", 32'(busy),    32'd1);

        // ---- 2: everyone requesting, every stb acked -> rotation ----
        set_in(4'b1111, 4'b1111, '0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step($sformatf("t2_%0d", k));
            chk($sformatf("t2_rot%0d", k), 32'(gnt_idx), 32'(exp_seq[k]));
        end

        // ---- 3: locked master keeps the bus across acked transfers ----
        set_in('0, '0, '0, 1'b0);
        step("t3_idle");
        set_in(4'b0010, '0, 4'b0010, 1'b0);
        step("t3_lockg");
        set_in(4'b0111, 4'b0010, 4'b0010, 1'b0);
        for (int k = 0; k < 10; k++) begin
            ack = (k % 2 == 1);
            step($sformatf("t3_%0d", k));
            chk($sformatf("t3_hold%0d", k), 32'(gnt), 32'h2);
        end
        set_in(4'b0101, '0, '0, 1'b0);
        step("t3_rel");
        chk("t3_next_m2", 32'(gnt), 32'h4);

        // ---- 4: hung transfer -> pulse on the 9th stb cycle, then revoke ----
        set_in('0, '0, '0, 1'b0);
        step("t4_idle");
        set_in(4'b0001, 4'b0001, '0, 1'b0);
        step("t4_gnt");
        for (int k = 1; k <= 8; k++) begin
            step($sformatf("t4_%0d", k));
            chk($sformatf("t4_wdt%0d", k), 32'(wdt_err), 32'(k == 8));
        end
        step("t4_rev");
        chk("t4_revoked", 32'(gnt), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("t4_ign%0d", k));
            chk($sformatf("t4_ignored%0d", k), 32'(gnt), 32'h0);
        end
        set_in(4'b0011, '0, '0, 1'b0);
        step("t4_m1");
        chk("t4_m1_gnt", 32'(gnt), 32'h2);
        set_in('0, '0, '0, 1'b0);
        step("t4_clr");

        // ---- 5: ack in the cycle the count would reach 8 wins ----
        set_in(4'b0001, 4'b0001, '0, 1'b0);
        step("t5_gnt");
        for (int k = 1; k <= 7; k++) step($sformatf("t5_%0d", k));
        ack = 1'b1;
        step("t5_ack");
        chk("t5_no_pulse", 32'(wdt_err), 32'd0);
        ack = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step($sformatf("t5_r%0d", k));
            chk($sformatf("t5_restart%0d", k), 32'(wdt_err), 32'(k == 8));
        end
        step("t5_rev");
        set_in('0, '0, '0, 1'b0);
        step("t5_clr");

        // ---- 6: async reset mid locked transfer ----
        set_in(4'b0100, 4'b0100, 4'b0100, 1'b0);
        step("t6_gnt");
        chk("t6_locked", 32'(locked), 32'd1);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_gnt",    32'(gnt),     32'd0);
        chk("t6_rst_idx",    32'(gnt_idx), 32'd0);
        chk("t6_rst_busy",   32'(busy),    32'd0);
        chk("t6_rst_locked", 32'(locked),  32'd0);
        chk("t6_rst_wdt",    32'(wdt_err), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step("t6_regnt");
        chk("t6_regnt_m2", 32'(gnt), 32'h4);

        // ---- randomized run against the model ----
        set_in('0, '0, '0, 1'b0);
        step("rnd_start");
        for (int c = 0; c < 600; c++) begin
            quiet = ((c / 50) % 2) == 1;
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(15) == 0) cyc[i] = ~cyc[i];
                if ($urandom_range(7) == 0)  lkst[i] = ~lkst[i];
                stb[i]  = cyc[i] && ($urandom_range(3) != 0);
                lock[i] = cyc[i] && lkst[i];
            end
            r   = int'($urandom_range(quiet ? 39 : 5));
            ack = (r == 0);
            err = (r == 1);
            rty = (r == 2);
            step($sformatf("rnd%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
